// File: rtl/multiply_pkg.sv
// ============================================================================
// multiply_pkg : shared state encoding and sizing constants for multiply
// Rev 1.0
// ============================================================================
`default_nettype none

package multiply_pkg;

  localparam int c_WIDTH_DEFAULT = 16;

  // The counter needs one spare bit so it can count all the way to WIDTH.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int c_CNT_W_DEFAULT = cnt_width(c_WIDTH_DEFAULT);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/multiply.sv
// ============================================================================
// multiply : sequential shift-and-add multiplier, low WIDTH bits of x*y
// Rev 1.0
// ============================================================================
`default_nettype none

module multiply
  import multiply_pkg::*;
#(
  parameter int WIDTH = c_WIDTH_DEFAULT
) (
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             reset,
  input  logic             clk
);

  localparam int                CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  c_LAST   = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ma_q, ma_d;
  logic [WIDTH-1:0] mb_q, mb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] w_acc_next;

  assign w_acc_next = mb_q[0] ? (acc_q + ma_q) : acc_q;

  always_comb begin
    state_d = state_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    case (state_q)
      LOAD: begin
        ma_d    = x;
        mb_d    = y;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        acc_d = w_acc_next;
        ma_d  = ma_q << 1;
        mb_d  = mb_q >> 1;
        cnt_d = cnt_q + 1'b1;
        // The result only becomes visible once the full product is formed.
        if (cnt_q == c_LAST) begin
          out_d   = w_acc_next;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD;
      ma_q    <= '0;
      mb_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign out = out_q;

endmodule

`default_nettype wire

// File: tb/tb_multiply.sv
// ============================================================================
// tb_multiply : directed and randomized checks of multiply against x*y mod 2^16
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_multiply;

  localparam int W = 16;

  logic         clk;
  logic         reset;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic [W-1:0] dut_out;

  int tests;
  int fails;

  multiply #(.WIDTH(W)) dut (
    .out   (dut_out),
    .x     (x),
    .y     (y),
    .reset (reset),
    .clk   (clk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return p[W-1:0];
  endfunction

  task automatic check(input string tag, input logic [W-1:0] exp);
    tests++;
    assert (dut_out === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, dut_out, exp);
    end
  endtask

  task automatic hold_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    check("reset", '0);
  endtask

  // Releases reset with operands a/b and clocks edges E0..E20. If perturb is
  // set the inputs are scrambled during RUN and again during DONE.
  task automatic run_op(input string tag, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit perturb, input bit full);
    logic [W-1:0] prod;
    prod  = model(a, b);
    x     = a;
    y     = b;
    reset = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (perturb && (k == 5 || k == 18)) begin
        x = W'($urandom);
        y = W'($urandom);
      end
      if (full || k == 15 || k == 16 || k == 20)
        check(tag, (k >= 16) ? prod : '0);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    x     = '0;
    y     = '0;

    hold_reset(10);
    run_op("3x2", 16'd3, 16'd2, 1'b0, 1'b1);
    hold_reset(10);
    run_op("3x6_rearm", 16'd3, 16'd6, 1'b0, 1'b1);

    hold_reset(2);
    run_op("ffff_sq", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    hold_reset(2);
    run_op("256x256", 16'd256, 16'd256, 1'b0, 1'b0);
    hold_reset(2);
    run_op("0x1234", 16'd0, 16'd1234, 1'b0, 1'b0);
    hold_reset(2);
    run_op("1234x0", 16'd1234, 16'd0, 1'b0, 1'b0);
    hold_reset(2);
    run_op("1xffff", 16'd1, 16'hFFFF, 1'b0, 1'b0);
    hold_reset(2);
    run_op("in_change", 16'd3, 16'd6, 1'b1, 1'b0);

    // Reset one edge while in DONE must clear the held result immediately.
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("done_abort", '0);

    // Abort mid-RUN at E8, then restart with 5x5.
    hold_reset(2);
    x     = 16'd3;
    y     = 16'd6;
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_abort", '0);
    x     = 16'd5;
    y     = 16'd5;
    reset = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      @(posedge clk);
      #1;
      check("5x5_after_abort", (k == 16) ? 16'd25 : 16'd0);
    end

    for (int i = 0; i < 20; i++) begin
      hold_reset(1 + int'($urandom_range(3)));
      run_op("random", W'($urandom), W'($urandom), i[0], 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
